// File: rtl/multicycle_pkg.sv
// multicycle_pkg: state encodings, opcodes and datapath select codes shared by the multicycle MIPS control.
package multicycle_pkg;
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTYPE  = 4'd6,
      S_RWB    = 4'd7,
      S_BEQ    = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDI   = 4'd10,
      S_IWB    = 4'd11,
      S_BNE    = 4'd12,
      S_SLTI   = 4'd13,
      S_HALT   = 4'd15
   } state_t;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_SLT   = 2'b11;
   localparam logic [1:0] ALUSRCB_B     = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
   localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
endpackage

// File: rtl/multicycle_ctrl_decode.sv
// multicycle_ctrl_decode: combinational decode of FSM state (plus zero and mem_ready) into datapath controls.
module multicycle_ctrl_decode
   import multicycle_pkg::*;
(
   input  logic [3:0] i_state,
   input  logic       i_zero,
   input  logic       i_mem_ready,
   output logic       o_pc_en,
   output logic       o_iord,
   output logic       o_mem_read,
   output logic       o_mem_write,
   output logic       o_ir_write,
   output logic       o_mem_to_reg,
   output logic       o_reg_dst,
   output logic       o_reg_write,
   output logic       o_alu_src_a,
   output logic [1:0] o_alu_src_b,
   output logic [1:0] o_alu_op,
   output logic [1:0] o_pc_source,
   output logic       o_halt
);
   always_comb begin
      o_pc_en      = 1'b0;
      o_iord       = 1'b0;
      o_mem_read   = 1'b0;
      o_mem_write  = 1'b0;
      o_ir_write   = 1'b0;
      o_mem_to_reg = 1'b0;
      o_reg_dst    = 1'b0;
      o_reg_write  = 1'b0;
      o_alu_src_a  = 1'b0;
      o_alu_src_b  = ALUSRCB_B;
      o_alu_op     = ALUOP_ADD;
      o_pc_source  = PCSRC_ALU;
      o_halt       = 1'b0;
      case (i_state)
         S_FETCH: begin
            // PC+4 and IR load happen only on the cycle the memory delivers
            o_mem_read  = 1'b1;
            o_alu_src_b = ALUSRCB_FOUR;
            o_ir_write  = i_mem_ready;
            o_pc_en     = i_mem_ready;
         end
         S_DECODE: o_alu_src_b = ALUSRCB_IMMSH;
         S_MEMADR: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = ALUSRCB_IMM;
         end
         S_MEMRD: begin
            o_mem_read = 1'b1;
            o_iord     = 1'b1;
         end
         S_MEMWB: begin
            o_reg_write  = 1'b1;
            o_mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            o_mem_write = 1'b1;
            o_iord      = 1'b1;
         end
         S_RTYPE: begin
            o_alu_src_a = 1'b1;
            o_alu_op    = ALUOP_FUNCT;
         end
         S_RWB: begin
            o_reg_write = 1'b1;
            o_reg_dst   = 1'b1;
         end
         S_BEQ, S_BNE: begin
            o_alu_src_a = 1'b1;
            o_alu_op    = ALUOP_SUB;
            o_pc_source = PCSRC_ALUOUT;
            o_pc_en     = (i_state == S_BEQ) ? i_zero : ~i_zero;
         end
         S_JUMP: begin
            o_pc_source = PCSRC_JUMP;
            o_pc_en     = 1'b1;
         end
         S_ADDI: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = ALUSRCB_IMM;
         end
         S_SLTI: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = ALUSRCB_IMM;
            o_alu_op    = ALUOP_SLT;
         end
         S_IWB: o_reg_write = 1'b1;
         S_HALT: o_halt = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle MIPS CPU with memory-ready wait and illegal-opcode halt.
module multicycle_control
   import multicycle_pkg::*;
#(
   parameter bit WAIT_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       halt,
   output logic [3:0] state
);
   state_t     r_state;
   state_t     w_next;
   logic       w_ready;
   logic       w_pc_en;
   logic       w_iord;
   logic       w_mem_read;
   logic       w_mem_write;
   logic       w_ir_write;
   logic       w_mem_to_reg;
   logic       w_reg_dst;
   logic       w_reg_write;
   logic       w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic [1:0] w_alu_op;
   logic [1:0] w_pc_source;
   logic       w_halt;

   assign w_ready = !WAIT_EN || mem_ready;

   always_ff @(posedge clk or negedge rst)
      if (!rst) r_state <= S_FETCH;
      else      r_state <= w_next;

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
         S_DECODE:
            case (opcode)
               OP_RTYPE:     w_next = S_RTYPE;
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_BEQ:       w_next = S_BEQ;
               OP_BNE:       w_next = S_BNE;
               OP_J:         w_next = S_JUMP;
               OP_ADDI:      w_next = S_ADDI;
               OP_SLTI:      w_next = S_SLTI;
               default:      w_next = S_HALT;
            endcase
         S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  w_next = w_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  w_next = w_ready ? S_FETCH : S_MEMWR;
         S_RTYPE:  w_next = S_RWB;
         S_ADDI:   w_next = S_IWB;
         S_SLTI:   w_next = S_IWB;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_FETCH;
      endcase
   end

   multicycle_ctrl_decode u_decode (
      .i_state      (r_state),
      .i_zero       (zero),
      .i_mem_ready  (w_ready),
      .o_pc_en      (w_pc_en),
      .o_iord       (w_iord),
      .o_mem_read   (w_mem_read),
      .o_mem_write  (w_mem_write),
      .o_ir_write   (w_ir_write),
      .o_mem_to_reg (w_mem_to_reg),
      .o_reg_dst    (w_reg_dst),
      .o_reg_write  (w_reg_write),
      .o_alu_src_a  (w_alu_src_a),
      .o_alu_src_b  (w_alu_src_b),
      .o_alu_op     (w_alu_op),
      .o_pc_source  (w_pc_source),
      .o_halt       (w_halt)
   );

   // Gating by rst makes every strobe drop the instant reset asserts, not at the next edge
   assign {pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_source, halt} =
          rst ? {w_pc_en, w_iord, w_mem_read, w_mem_write, w_ir_write, w_mem_to_reg, w_reg_dst,
                 w_reg_write, w_alu_src_a, w_alu_src_b, w_alu_op, w_pc_source, w_halt} : 16'd0;
   assign state = r_state;
endmodule
